uart_tx_fifo: RTL

Buffered, parametrised UART transmitter for the DZ11 serial lines. A DEPTH-entry FIFO sits in front of a character serialiser, so software can queue several characters. The block also provides a configurable oversample ratio, mark parity, break generation, and an overrun flag. Line configuration is latched per character, so changes made mid-character do not corrupt the frame. One instance serves each DZ11 line, clocked by the shared baud-rate generator enable.

---
 rtl/uart_tx_fifo.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: DEPTH-entry character FIFO feeding a
// serialiser with per-character latched line configuration.
module uart_tx_fifo #(
   parameter int DEPTH      = 4,
   parameter int OVERSAMPLE = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic [1:0]               length,
   input  logic [1:0]               parity,
   input  logic                     stop,
   input  logic                     brk,
   input  logic                     brgCLKEN,
   input  logic [7:0]               data,
   input  logic                     load,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovr,
   output logic                     intr,
   output logic                     txd
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit;
   logic [TW-1:0]   r_tick;
   logic            r_par;
   logic [1:0]      r_len;
   logic [1:0]      r_pmode;
   logic            r_stop;
   logic            r_brk;
   logic            r_ovr;
   logic            r_intr;

   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_last;
   logic            w_pbit;

   assign w_full = (r_count == CNT_FULL);
   assign w_push = load && !w_full && !clr;
   assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && !brk && !clr;
   assign w_last = (r_bit == 3'd4 + {1'b0, r_len});

   always_comb begin
      w_pbit = 1'b1;
      case (r_pmode)
         2'b01:   w_pbit = ~r_par;
         2'b10:   w_pbit = r_par;
         default: w_pbit = 1'b1;
      endcase
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovr   <= 1'b0;
      end else if (clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovr   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_ovr <= load && w_full;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_tick  <= '0;
         r_par   <= 1'b0;
         r_len   <= '0;
         r_pmode <= '0;
         r_stop  <= 1'b0;
         r_brk   <= 1'b0;
         r_intr  <= 1'b0;
      end else if (clr) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_bit   <= '0;
         r_tick  <= '0;
         r_par   <= 1'b0;
         r_len   <= '0;
         r_pmode <= '0;
         r_stop  <= 1'b0;
         r_brk   <= 1'b0;
         r_intr  <= 1'b0;
      end else begin
         r_intr <= 1'b0;
         r_brk  <= brk;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shift <= r_mem[r_rptr];
                  r_len   <= length;
                  r_pmode <= parity;
                  r_stop  <= stop;
                  r_bit   <= '0;
                  r_par   <= 1'b0;
                  r_state <= S_SYNC;
               end
            end
            S_SYNC: begin
               if (brgCLKEN) begin
                  r_tick  <= TICK_MAX;
                  r_state <= S_START;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: begin
               if (brgCLKEN) begin
                  if (r_tick != '0) begin
                     r_tick <= r_tick - 1'b1;
                  end else begin
                     r_tick <= TICK_MAX;
                     case (r_state)
                        S_START: r_state <= S_DATA;
                        S_DATA: begin
                           r_shift <= {1'b0, r_shift[7:1]};
                           r_par   <= r_par ^ r_shift[0];
                           r_bit   <= r_bit + 1'b1;
                           if (w_last)
                              r_state <= (r_pmode != 2'b00) ? S_PARITY : S_STOP1;
                        end
                        S_PARITY: r_state <= S_STOP1;
                        S_STOP1: begin
                           if (r_stop) begin
                              r_state <= S_STOP2;
                           end else begin
                              r_state <= S_DONE;
                              r_intr  <= 1'b1;
                           end
                        end
                        S_STOP2: begin
                           r_state <= S_DONE;
                           r_intr  <= 1'b1;
                        end
                        default: r_state <= S_IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   // Break is sampled so txd stays a decode of registered state only.
   always_comb begin
      txd = 1'b1;
      case (r_state)
         S_START:  txd = 1'b0;
         S_DATA:   txd = r_shift[0];
         S_PARITY: txd = w_pbit;
         S_IDLE:   txd = ~r_brk;
         default:  txd = 1'b1;
      endcase
   end

   assign full  = w_full;
   assign empty = (r_count == '0) && (r_state == S_IDLE);
   assign count = r_count;
   assign ovr   = r_ovr;
   assign intr  = r_intr;

endmodule
